fifo_dp_ram_ctrl: RTL and testbench

Synchronous FIFO controller that sequences one 256x8 dual-port RAM instance, using port A as the write port and port B as the read port. It presents a valid/ready push interface and a first-word-fall-through pop interface. A 2-entry output queue absorbs the RAM's 1-cycle read latency so pop throughput is one word per clock. The RAM sits outside this block; the controller only drives its address, enable and write-enable pins.

---
 rtl/fifo_dp_ram_ctrl_if.sv | 22 ++
 rtl/fifo_dp_ram_ctrl.sv | 111 +++++++++++
 tb/tb_fifo_dp_ram_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_dp_ram_ctrl_if.sv
// Push/pop handshake bundle for fifo_dp_ram_ctrl.
// master: the producer/consumer side; slave: the FIFO controller.
interface fifo_dp_ram_ctrl_if #(
  parameter int unsigned D_W = 8
);
  logic           wr_valid;
  logic           wr_ready;
  logic [D_W-1:0] wr_data;
  logic           rd_valid;
  logic           rd_ready;
  logic [D_W-1:0] rd_data;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/fifo_dp_ram_ctrl.sv
// FIFO controller around an external dual-port RAM (port A write, port B read).
// A 2-entry output queue hides the RAM's 1-cycle read latency so the pop side
// is first-word-fall-through at one word per clock.
module fifo_dp_ram_ctrl #(
  parameter int unsigned D_W      = 8,
  parameter int unsigned A_W      = 8,
  parameter int unsigned AF_LEVEL = 240,
  parameter int unsigned AE_LEVEL = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush,
  fifo_dp_ram_ctrl_if.slave    bus,
  output logic [A_W+1:0]       count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [A_W-1:0]       ram_address_a,
  output logic [D_W-1:0]       ram_data_a,
  output logic                 ram_enable_a,
  output logic                 ram_wren_a,
  output logic [A_W-1:0]       ram_address_b,
  output logic                 ram_enable_b,
  output logic                 ram_wren_b,
  input  logic [D_W-1:0]       ram_q_b
);

  localparam logic [A_W:0] DEPTH = {1'b1, {A_W{1'b0}}};

  logic [A_W-1:0] wptr_q, wptr_d;
  logic [A_W-1:0] rptr_q, rptr_d;
  logic [A_W:0]   mem_cnt_q, mem_cnt_d;
  logic           pend_q, pend_d;
  logic [1:0]     occ_q, occ_d;
  logic [D_W-1:0] oq_q [2];
  logic [D_W-1:0] oq_d [2];

  logic accept, pop, issue;
  logic [2:0] oq_demand;

  // Handshakes, RAM port drive and status flags from registered state
  always_comb begin
    full         = (mem_cnt_q == DEPTH);
    bus.wr_ready = ~full & reset_n & ~flush;
    accept       = bus.wr_valid & bus.wr_ready;

    bus.rd_valid = (occ_q != 2'd0);
    bus.rd_data  = oq_q[0];
    pop          = bus.rd_valid & bus.rd_ready;

    // Slots the output queue will need next cycle if another read launches now
    oq_demand    = 3'(occ_q) + 3'(pend_q) - 3'(pop);
    issue        = (mem_cnt_q != '0) & (oq_demand < 3'd2) & ~flush & reset_n;

    count        = (A_W+2)'(mem_cnt_q) + (A_W+2)'(pend_q) + (A_W+2)'(occ_q);
    empty        = (count == '0);
    almost_full  = (count >= (A_W+2)'(AF_LEVEL));
    almost_empty = (count <= (A_W+2)'(AE_LEVEL));

    ram_enable_a  = accept;
    ram_wren_a    = accept;
    ram_address_a = wptr_q;
    ram_data_a    = bus.wr_data;
    ram_enable_b  = issue;
    ram_wren_b    = 1'b0;
    ram_address_b = rptr_q;
  end

  // Next-state: pointers, RAM occupancy, and output queue shift/fill
  always_comb begin
    wptr_d    = wptr_q + A_W'(accept);
    rptr_d    = rptr_q + A_W'(issue);
    mem_cnt_d = mem_cnt_q + (A_W+1)'(accept) - (A_W+1)'(issue);
    pend_d    = issue;
    oq_d      = oq_q;
    occ_d     = occ_q;
    // Pop shifts first so the returning RAM word lands in the freed tail slot
    if (pop) begin
      oq_d[0] = oq_q[1];
      occ_d   = occ_q - 2'd1;
    end
    if (pend_q) begin
      oq_d[occ_d[0]] = ram_q_b;
      occ_d          = occ_d + 2'd1;
    end
  end

  // Control state; reset and flush both clear it, dropping any in-flight read
  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      mem_cnt_q <= '0;
      pend_q    <= 1'b0;
      occ_q     <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      mem_cnt_q <= mem_cnt_d;
      pend_q    <= pend_d;
      occ_q     <= occ_d;
    end
  end

  // Output queue data; contents are meaningless while occ_q marks them empty
  always_ff @(posedge clock) begin
    oq_q <= oq_d;
  end

endmodule

// File: tb/tb_fifo_dp_ram_ctrl.sv
// Self-checking bench for fifo_dp_ram_ctrl with a behavioural RAM and a
// queue-based reference model of the FIFO contents and latency.
module tb_fifo_dp_ram_ctrl;

  logic       clock;
  logic       reset_n;
  logic       flush;
  logic [9:0] count;
  logic       full, empty, almost_full, almost_empty;
  logic [7:0] ram_address_a, ram_data_a, ram_address_b;
  logic       ram_enable_a, ram_wren_a, ram_enable_b, ram_wren_b;
  logic [7:0] ram_q_b;

  fifo_dp_ram_ctrl_if #(.D_W(8)) bus ();

  fifo_dp_ram_ctrl #(
    .D_W(8), .A_W(8), .AF_LEVEL(240), .AE_LEVEL(16)
  ) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .bus(bus),
    .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .ram_address_a(ram_address_a), .ram_data_a(ram_data_a),
    .ram_enable_a(ram_enable_a), .ram_wren_a(ram_wren_a),
    .ram_address_b(ram_address_b), .ram_enable_b(ram_enable_b),
    .ram_wren_b(ram_wren_b), .ram_q_b(ram_q_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural 256x8 dual-port RAM
  logic [7:0] mem [256];
  always @(posedge clock) begin
    if (ram_enable_a && ram_wren_a) mem[ram_address_a] <= ram_data_a;
    if (ram_enable_b) ram_q_b <= mem[ram_address_b];
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: words held, the edge each was accepted, write address
  logic [7:0]  mq [$];
  int unsigned mt [$];
  int unsigned edge_n = 0;
  int unsigned acc_total = 0;
  logic [7:0]  wptr_m = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check outputs at negedge, advance the model
  task automatic cycle(input logic wv, input logic [7:0] wd, input logic rr,
                       input logic fl, input logic rn);
    logic acc, pp, vexp;
    int unsigned n;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_ready = rr;
    flush        = fl;
    reset_n      = rn;
    @(negedge clock);
    n = mq.size();
    check_eq("count", 32'(count), n);
    check_eq("empty", 32'(empty), 32'(n == 0));
    check_eq("almost_full", 32'(almost_full), 32'(n >= 240));
    check_eq("almost_empty", 32'(almost_empty), 32'(n <= 16));
    vexp = 1'b0;
    if (n != 0) vexp = ((edge_n - mt[0]) >= 2);
    check_eq("rd_valid", 32'(bus.rd_valid), 32'(vexp));
    if (!rn || fl) begin
      check_eq("wr_ready_clr", 32'(bus.wr_ready), 0);
      check_eq("ren_b_clr", 32'(ram_enable_b), 0);
    end else if (n < 256) begin
      check_eq("wr_ready", 32'(bus.wr_ready), 1);
    end
    if (n < 256) check_eq("full_lo", 32'(full), 0);
    if (n == 258) check_eq("full_hi", 32'(full), 1);
    acc = wv & bus.wr_ready;
    check_eq("ram_en_a", 32'(ram_enable_a), 32'(acc));
    check_eq("ram_wren_a", 32'(ram_wren_a), 32'(acc));
    if (acc) begin
      check_eq("ram_addr_a", 32'(ram_address_a), 32'(wptr_m));
      check_eq("ram_data_a", 32'(ram_data_a), 32'(wd));
    end
    check_eq("ram_wren_b", 32'(ram_wren_b), 0);
    check_eq("collision", 32'(ram_enable_a && ram_enable_b && (ram_address_a == ram_address_b)), 0);
    pp = bus.rd_valid & rr & rn & ~fl;
    if (pp && n != 0) check_eq("rd_data", 32'(bus.rd_data), 32'(mq[0]));
    @(posedge clock);
    edge_n++;
    if (!rn || fl) begin
      mq.delete();
      mt.delete();
      wptr_m = '0;
    end else begin
      if (pp && n != 0) begin
        void'(mq.pop_front());
        void'(mt.pop_front());
      end
      if (acc) begin
        mq.push_back(wd);
        mt.push_back(edge_n);
        wptr_m++;
        acc_total++;
      end
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && mq.size() != 0; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check_eq("drain_count", 32'(count), 0);
  endtask

  int unsigned base;

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
    flush        = 1'b0;
    reset_n      = 1'b0;
    @(posedge clock);
    #1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Short burst then in-order pop
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("burst_count", 32'(count), 5);
    check_eq("burst_ae", 32'(almost_empty), 1);
    drain();

    // Fill to capacity with the reader stalled
    base = acc_total;
    for (int i = 0; i < 262; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
    check_eq("fill_accepts", acc_total - base, 258);
    check_eq("fill_count", 32'(count), 258);
    check_eq("fill_full", 32'(full), 1);
    check_eq("fill_wr_ready", 32'(bus.wr_ready), 0);
    drain();

    // Streaming push+pop every cycle
    for (int i = 0; i < 600; i++) begin
      cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1);
      if (i > 4) check_eq("stream_occ", 32'(count <= 10'd3), 1);
    end
    drain();

    // Random traffic
    for (int i = 0; i < 2000; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    drain();

    // Flush with a push offered and a read in flight
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
    check_eq("flush_count", 32'(count), 0);
    check_eq("flush_rd_valid", 32'(bus.rd_valid), 0);
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("flush_head", 32'(bus.rd_data), 32'h0A5);
    drain();

    // Reset pulse mid-stream
    for (int i = 0; i < 100; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_empty", 32'(empty), 1);
    for (int i = 0; i < 30; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
